// File: rtl/ram_stream_master_pkg.sv
//------------------------------------------------------------------------------
// Module   : ram_stream_master_pkg
// Brief    : Shared state encoding, mode constants and default widths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_stream_master_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_CNT_W  = 13;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LD_HI   = 4'd1,
        ST_LD_LO   = 4'd2,
        ST_LD_WR   = 4'd3,
        ST_RD_REQ  = 4'd4,
        ST_RD_WAIT = 4'd5,
        ST_DP_HI   = 4'd6,
        ST_DP_LO   = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_stream_master_byte_word_pack.sv
//------------------------------------------------------------------------------
// Module   : byte_word_pack
// Brief    : Byte<->word serializer: word register, byte select, checksum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_word_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_sum,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [7:0]  byte_in,
    input  logic        cap,
    input  logic [15:0] cap_data,
    input  logic        add_word,
    input  logic        sel_hi,
    output logic [15:0] word_next,
    output logic [7:0]  byte_out,
    output logic [15:0] sum
);

    logic [15:0] r_word;
    logic [15:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word <= 16'h0000;
            r_sum  <= 16'h0000;
        end else begin
            if (wr_hi)
                r_word[15:8] <= byte_in;
            if (wr_lo)
                r_word[7:0] <= byte_in;
            if (cap)
                r_word <= cap_data;

            if (clr_sum)
                r_sum <= 16'h0000;
            else if (add_word)
                r_sum <= r_sum + r_word;
            else if (cap)
                r_sum <= r_sum + cap_data;
        end
    end

    // Word as it will be after this cycle's low-byte handshake, so the
    // write data register can be loaded on the same edge.
    always_comb begin
        word_next = r_word;
        if (wr_lo)
            word_next = {r_word[15:8], byte_in};
    end

    assign byte_out = sel_hi ? r_word[15:8] : r_word[7:0];
    assign sum      = r_sum;

endmodule

`default_nettype wire

// File: rtl/ram_stream_master.sv
//------------------------------------------------------------------------------
// Module   : ram_stream_master
// Brief    : Streams bytes into / out of a 4K x 16 synchronous RAM port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_stream_master
    import ram_stream_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    output logic [ADDR_W-1:0] ram_address,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    output logic              ram_rnw,
    output logic              ram_cs_b
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cs_b;
    logic              r_rnw;
    logic [ADDR_W-1:0] r_ram_address;
    logic [15:0]       r_ram_din;

    logic              w_start_acc;
    logic              w_wr_hi;
    logic              w_wr_lo;
    logic              w_sel_hi;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [15:0]       w_word_next;
    logic [7:0]        w_byte;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0)
                        w_next = ST_DONE;
                    else if (mode == MODE_LOAD)
                        w_next = ST_LD_HI;
                    else
                        w_next = ST_RD_REQ;
                end
            end
            ST_LD_HI:   if (in_valid) w_next = ST_LD_LO;
            ST_LD_LO:   if (in_valid) w_next = ST_LD_WR;
            ST_LD_WR:   w_next = (r_cnt == CNT_W'(1)) ? ST_DONE : ST_LD_HI;
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: w_next = ST_DP_HI;
            ST_DP_HI:   if (out_ready) w_next = ST_DP_LO;
            ST_DP_LO: begin
                if (out_ready)
                    w_next = (r_cnt == '0) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_LD_HI) || (r_state == ST_LD_LO);
        out_valid = (r_state == ST_DP_HI) || (r_state == ST_DP_LO);
        busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done      = (r_state == ST_DONE);
        w_sel_hi  = (r_state == ST_DP_HI);
    end

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_wr_hi     = (r_state == ST_LD_HI) && in_valid;
    assign w_wr_lo     = (r_state == ST_LD_LO) && in_valid;
    // A read can be issued straight out of IDLE, before r_addr is loaded.
    assign w_acc_addr  = w_start_acc ? base_addr : r_addr;

    // RAM strobes are registered from the next state so they line up with
    // the LD_WR / RD_REQ cycles themselves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_cnt         <= '0;
            r_cs_b        <= 1'b1;
            r_rnw         <= 1'b1;
            r_ram_address <= '0;
            r_ram_din     <= 16'h0000;
        end else begin
            r_cs_b <= 1'b1;
            r_rnw  <= 1'b1;
            if (w_start_acc) begin
                r_addr <= base_addr;
                r_cnt  <= word_count;
            end
            if (w_next == ST_LD_WR) begin
                r_cs_b        <= 1'b0;
                r_rnw         <= 1'b0;
                r_ram_address <= w_acc_addr;
                r_ram_din     <= w_word_next;
            end
            if (w_next == ST_RD_REQ) begin
                r_cs_b        <= 1'b0;
                r_ram_address <= w_acc_addr;
            end
            if ((r_state == ST_LD_WR) || (r_state == ST_RD_WAIT)) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    byte_word_pack u_pack (
        .clk       (clk),
        .reset     (reset),
        .clr_sum   (w_start_acc),
        .wr_hi     (w_wr_hi),
        .wr_lo     (w_wr_lo),
        .byte_in   (in_data),
        .cap       (r_state == ST_RD_WAIT),
        .cap_data  (ram_dout),
        .add_word  (r_state == ST_LD_WR),
        .sel_hi    (w_sel_hi),
        .word_next (w_word_next),
        .byte_out  (w_byte),
        .sum       (checksum)
    );

    assign out_data    = out_valid ? w_byte : 8'h00;
    assign ram_cs_b    = r_cs_b;
    assign ram_rnw     = r_rnw;
    assign ram_address = r_ram_address;
    assign ram_din     = r_ram_din;

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_master.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_stream_master
// Brief    : Scoreboard bench for ram_stream_master with a behavioural RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_stream_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic [11:0] ram_address;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        ram_rnw;
    logic        ram_cs_b;

    logic [15:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    int rd_cyc[$];

    logic [7:0]  exp_byte[$];
    logic [27:0] exp_wr[$];
    logic [15:0] exp_sum[$];

    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    ram_stream_master dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum),
        .ram_address (ram_address),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_rnw     (ram_rnw),
        .ram_cs_b    (ram_cs_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_cs_b) begin
            if (!ram_rnw)
                mem[ram_address] <= ram_din;
            else
                ram_dout <= mem[ram_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_cs_b && !ram_rnw) begin
                n_wr++;
                if (exp_wr.size() == 0)
                    chk("unexpected_write", {4'h0, ram_address, ram_din}, 32'h0);
                else
                    chk("ram_write", {4'h0, ram_address, ram_din}, {4'h0, exp_wr.pop_front()});
            end
            if (!ram_cs_b && ram_rnw) begin
                n_rd++;
                rd_cyc.push_back(cyc);
            end
            if (stall_prev && out_valid)
                chk("out_data_stable", {24'h0, out_data}, {24'h0, stall_data});
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_byte.size() == 0)
                    chk("unexpected_byte", {24'h0, out_data}, 32'hFFFF_FFFF);
                else
                    chk("out_byte", {24'h0, out_data}, {24'h0, exp_byte.pop_front()});
            end
            if (done) begin
                if (exp_sum.size() == 0)
                    chk("unexpected_done", {16'h0, checksum}, 32'hFFFF_FFFF);
                else
                    chk("checksum", {16'h0, checksum}, {16'h0, exp_sum.pop_front()});
            end
        end
    end

    task automatic start_cmd(input logic m, input logic [11:0] b, input logic [12:0] c);
        start = 1'b1; mode = m; base_addr = b; word_count = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got = 1'b0;
        in_data = b; in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        chk("in_ready_seen", {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for done; with stall set, out_ready is high one cycle in three.
    task automatic wait_done(input logic stall);
        logic got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = done;
            @(posedge clk); #1;
            out_ready = stall ? ((i % 3) == 2) : 1'b1;
        end
        chk("done_seen", {31'h0, got}, 32'h1);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rd0, c0;
        logic got;
        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; word_count = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_cs_b",      {31'h0, ram_cs_b},    32'h1);
        chk("rst_rnw",       {31'h0, ram_rnw},     32'h1);
        chk("rst_address",   {20'h0, ram_address}, 32'h0);
        chk("rst_din",       {16'h0, ram_din},     32'h0);
        chk("rst_in_ready",  {31'h0, in_ready},    32'h0);
        chk("rst_out_valid", {31'h0, out_valid},   32'h0);
        chk("rst_out_data",  {24'h0, out_data},    32'h0);
        chk("rst_busy",      {31'h0, busy},        32'h0);
        chk("rst_done",      {31'h0, done},        32'h0);
        chk("rst_checksum",  {16'h0, checksum},    32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Load two words big-endian from 0x010
        wr0 = n_wr;
        exp_wr.push_back({12'h010, 16'h1234});
        exp_wr.push_back({12'h011, 16'hABCD});
        exp_sum.push_back(16'hBE01);
        start_cmd(1'b0, 12'h010, 13'd2);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        wait_done(1'b0);
        chk("load_write_count", n_wr - wr0, 2);
        chk("mem_010", {16'h0, mem[12'h010]}, 32'h1234);
        chk("mem_011", {16'h0, mem[12'h011]}, 32'hABCD);

        // Dump the same two words at full rate
        rd_cyc.delete();
        rd0 = n_rd;
        exp_byte.push_back(8'h12); exp_byte.push_back(8'h34);
        exp_byte.push_back(8'hAB); exp_byte.push_back(8'hCD);
        exp_sum.push_back(16'hBE01);
        start_cmd(1'b1, 12'h010, 13'd2);
        wait_done(1'b0);
        chk("dump_read_count", n_rd - rd0, 2);
        if (rd_cyc.size() == 2)
            chk("read_spacing", rd_cyc[1] - rd_cyc[0], 4);
        else
            chk("read_cycles_recorded", rd_cyc.size(), 2);

        // Dump with a stalling consumer
        rd0 = n_rd;
        exp_byte.push_back(8'h12); exp_byte.push_back(8'h34);
        exp_byte.push_back(8'hAB); exp_byte.push_back(8'hCD);
        exp_sum.push_back(16'hBE01);
        out_ready = 1'b0;
        start_cmd(1'b1, 12'h010, 13'd2);
        wait_done(1'b1);
        chk("stall_read_count", n_rd - rd0, 2);

        // Address wrap at the top of RAM
        exp_wr.push_back({12'hFFF, 16'h0001});
        exp_wr.push_back({12'h000, 16'h0002});
        exp_sum.push_back(16'h0003);
        start_cmd(1'b0, 12'hFFF, 13'd2);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        wait_done(1'b0);
        chk("mem_fff", {16'h0, mem[12'hFFF]}, 32'h0001);
        chk("mem_000", {16'h0, mem[12'h000]}, 32'h0002);

        // Zero count completes with no RAM traffic
        wr0 = n_wr; rd0 = n_rd; c0 = cyc;
        exp_sum.push_back(16'h0000);
        start_cmd(1'b1, 12'h123, 13'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("zero_done_seen", {31'h0, got}, 32'h1);
        chk("zero_done_latency", cyc - c0, 1);
        chk("zero_no_access", (n_wr - wr0) + (n_rd - rd0), 0);
        @(posedge clk); #1;

        // Start while busy is ignored
        rd0 = n_rd;
        exp_byte.push_back(8'h12); exp_byte.push_back(8'h34);
        exp_sum.push_back(16'h1234);
        start_cmd(1'b1, 12'h010, 13'd1);
        start_cmd(1'b0, 12'h000, 13'd0);
        wait_done(1'b0);
        chk("busy_start_read_count", n_rd - rd0, 1);

        // Reset after one load byte, then a clean load
        start_cmd(1'b0, 12'h020, 13'd1);
        send_byte(8'h55);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cs_b",     {31'h0, ram_cs_b}, 32'h1);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("post_rst_busy",     {31'h0, busy},     32'h0);
        @(posedge clk); #1;
        exp_wr.push_back({12'h020, 16'h9ABC});
        exp_sum.push_back(16'h9ABC);
        start_cmd(1'b0, 12'h020, 13'd1);
        send_byte(8'h9A); send_byte(8'hBC);
        wait_done(1'b0);
        chk("mem_020", {16'h0, mem[12'h020]}, 32'h9ABC);

        repeat (3) @(posedge clk);
        chk("exp_wr_drained",   exp_wr.size(),   0);
        chk("exp_byte_drained", exp_byte.size(), 0);
        chk("exp_sum_drained",  exp_sum.size(),  0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
